// File: rtl/apb_slice_pkg.sv
// Shared types and constants for the registered APB3 slice.
// The transfer-timeout option is controlled by the APB_SLICE_TIMEOUT_EN macro.
package apb_slice_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DSETUP,
        DACCESS,
        RESP
    } state_e;

    localparam int TIMEOUT_CNT_WIDTH = 16;

endpackage

// File: rtl/apb_slice_timer.sv
// Access-phase watchdog for the APB slice; only instantiated when APB_SLICE_TIMEOUT_EN is defined.
// expired_o flags the enabled cycle on which the count would reach LIMIT.
module apb_slice_timer
    import apb_slice_pkg::*;
#(
    parameter int unsigned LIMIT = 256
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [TIMEOUT_CNT_WIDTH-1:0] LAST = TIMEOUT_CNT_WIDTH'(LIMIT - 1);

    logic [TIMEOUT_CNT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign expired_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/apb_reg_slice.sv
// Registered APB3 bridge: every request and response signal crosses one flop stage.
// Define APB_SLICE_TIMEOUT_EN to abort downstream accesses after TIMEOUT_CYCLES wait cycles.
module apb_reg_slice
    import apb_slice_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic [ADDR_WIDTH-1:0] up_paddr,
    input  logic [DATA_WIDTH-1:0] up_pwdata,
    input  logic                  up_pwrite,
    input  logic                  up_psel,
    input  logic                  up_penable,
    output logic [DATA_WIDTH-1:0] up_prdata,
    output logic                  up_pready,
    output logic                  up_pslverr,
    output logic [ADDR_WIDTH-1:0] dn_paddr,
    output logic [DATA_WIDTH-1:0] dn_pwdata,
    output logic                  dn_pwrite,
    output logic                  dn_psel,
    output logic                  dn_penable,
    input  logic [DATA_WIDTH-1:0] dn_prdata,
    input  logic                  dn_pready,
    input  logic                  dn_pslverr
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES >= (1 << TIMEOUT_CNT_WIDTH)) begin : g_bad_timeout
        $error("apb_reg_slice: TIMEOUT_CYCLES out of range 1..65535");
    end

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] paddr_q;
    logic [DATA_WIDTH-1:0] pwdata_q;
    logic                  pwrite_q;
    logic                  psel_q;
    logic                  penable_q;
    logic [DATA_WIDTH-1:0] prdata_q;
    logic                  pready_q;
    logic                  pslverr_q;
    logic                  timeout;

`ifdef APB_SLICE_TIMEOUT_EN
    apb_slice_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timer (
        .clk_i     (HCLK),
        .rst_ni    (HRESETn),
        .clr_i     ((state_q != DACCESS) || dn_pready),
        .en_i      ((state_q == DACCESS) && !dn_pready),
        .expired_o (timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q   <= IDLE;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pwrite_q  <= 1'b0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // Only a setup phase starts a transfer, so a master that lingers in
                    // its access phase after the response cannot launch a duplicate.
                    if (up_psel && !up_penable) begin
                        paddr_q  <= up_paddr;
                        pwdata_q <= up_pwdata;
                        pwrite_q <= up_pwrite;
                        psel_q   <= 1'b1;
                        state_q  <= DSETUP;
                    end
                end
                DSETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= DACCESS;
                end
                DACCESS: begin
                    // A ready slave takes priority over a same-cycle timeout.
                    if (dn_pready) begin
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        prdata_q  <= pwrite_q ? '0 : dn_prdata;
                        pslverr_q <= dn_pslverr;
                        pready_q  <= 1'b1;
                        state_q   <= RESP;
                    end else if (timeout) begin
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        prdata_q  <= '0;
                        pslverr_q <= 1'b1;
                        pready_q  <= 1'b1;
                        state_q   <= RESP;
                    end
                end
                RESP: begin
                    pready_q <= 1'b0;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign up_prdata  = prdata_q;
    assign up_pready  = pready_q;
    assign up_pslverr = pslverr_q;
    assign dn_paddr   = paddr_q;
    assign dn_pwdata  = pwdata_q;
    assign dn_pwrite  = pwrite_q;
    assign dn_psel    = psel_q;
    assign dn_penable = penable_q;

endmodule

// File: tb/tb_apb_reg_slice.sv
// Directed bench for apb_reg_slice; the timeout scenario runs when APB_SLICE_TIMEOUT_EN is defined.
module tb_apb_reg_slice;

    logic        HCLK;
    logic        HRESETn;
    logic [31:0] up_paddr, up_pwdata, up_prdata;
    logic        up_pwrite, up_psel, up_penable, up_pready, up_pslverr;
    logic [31:0] dn_paddr, dn_pwdata, dn_prdata;
    logic        dn_pwrite, dn_psel, dn_penable, dn_pready, dn_pslverr;

    int n_tests = 0;
    int n_fail  = 0;

    apb_reg_slice #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .up_paddr   (up_paddr),
        .up_pwdata  (up_pwdata),
        .up_pwrite  (up_pwrite),
        .up_psel    (up_psel),
        .up_penable (up_penable),
        .up_prdata  (up_prdata),
        .up_pready  (up_pready),
        .up_pslverr (up_pslverr),
        .dn_paddr   (dn_paddr),
        .dn_pwdata  (dn_pwdata),
        .dn_pwrite  (dn_pwrite),
        .dn_psel    (dn_psel),
        .dn_penable (dn_penable),
        .dn_prdata  (dn_prdata),
        .dn_pready  (dn_pready),
        .dn_pslverr (dn_pslverr)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_up_prdata"},  up_prdata,  0);
        chk({tag, "_up_pready"},  up_pready,  0);
        chk({tag, "_up_pslverr"}, up_pslverr, 0);
        chk({tag, "_dn_paddr"},   dn_paddr,   0);
        chk({tag, "_dn_pwdata"},  dn_pwdata,  0);
        chk({tag, "_dn_pwrite"},  dn_pwrite,  0);
        chk({tag, "_dn_psel"},    dn_psel,    0);
        chk({tag, "_dn_penable"}, dn_penable, 0);
    endtask

    // One upstream transfer starting at the next cycle; ends sampled in the RESP cycle.
    task automatic do_xfer(input logic [31:0] addr, input logic [31:0] wdata, input logic wr,
                           input int waits, input logic [31:0] rdata, input logic err);
        logic [31:0] exp_rd;
        exp_rd = wr ? 32'h0 : rdata;
        @(posedge HCLK); #1;
        up_psel = 1'b1; up_penable = 1'b0;
        up_paddr = addr; up_pwdata = wdata; up_pwrite = wr;
        dn_pready = 1'b0; dn_pslverr = 1'b0;
        @(negedge HCLK);
        chk("t0_up_pready", up_pready, 0);
        chk("t0_dn_psel",   dn_psel,   0);
        @(posedge HCLK); #1;
        up_penable = 1'b1;
        @(negedge HCLK);
        chk("setup_dn_psel",    dn_psel,    1);
        chk("setup_dn_penable", dn_penable, 0);
        chk("setup_dn_paddr",   dn_paddr,   addr);
        chk("setup_dn_pwdata",  dn_pwdata,  wdata);
        chk("setup_dn_pwrite",  dn_pwrite,  wr);
        for (int i = 0; i <= waits; i++) begin
            @(posedge HCLK); #1;
            dn_pready  = (i == waits);
            dn_prdata  = wr ? 32'hFFFF_FFFF : rdata;
            dn_pslverr = (i == waits) ? err : 1'b0;
            @(negedge HCLK);
            chk("acc_dn_psel",    dn_psel,    1);
            chk("acc_dn_penable", dn_penable, 1);
            chk("acc_up_pready",  up_pready,  0);
        end
        @(posedge HCLK); #1;
        dn_pready = 1'b0; dn_pslverr = 1'b0; dn_prdata = 32'h5A5A_5A5A;
        @(negedge HCLK);
        chk("resp_up_pready",  up_pready,  1);
        chk("resp_up_prdata",  up_prdata,  exp_rd);
        chk("resp_up_pslverr", up_pslverr, err);
        chk("resp_dn_psel",    dn_psel,    0);
        chk("resp_dn_penable", dn_penable, 0);
    endtask

    task automatic go_idle();
        @(posedge HCLK); #1;
        up_psel = 1'b0; up_penable = 1'b0;
        @(negedge HCLK);
        chk("idle_up_pready", up_pready, 0);
        chk("idle_dn_psel",   dn_psel,   0);
    endtask

    initial begin
        HRESETn = 1'b0;
        up_paddr = '0; up_pwdata = '0; up_pwrite = 1'b0; up_psel = 1'b0; up_penable = 1'b0;
        dn_prdata = '0; dn_pready = 1'b0; dn_pslverr = 1'b0;
        #12;
        chk_all_zero("reset");
        @(posedge HCLK); #1;
        HRESETn = 1'b1;

        // Zero-wait read
        do_xfer(32'h1A10_0004, 32'h0, 1'b0, 0, 32'hDEAD_BEEF, 1'b0);
        go_idle();
        chk("hold_dn_paddr", dn_paddr, 32'h1A10_0004);
        chk("hold_dn_pwrite", dn_pwrite, 0);

        // Write with three slave wait states
        do_xfer(32'h1A10_2000, 32'h0000_00A5, 1'b1, 3, 32'h0, 1'b0);
        go_idle();
        chk("hold_dn_pwdata", dn_pwdata, 32'h0000_00A5);

        // Slave error, then a clean transfer
        do_xfer(32'h1A10_0008, 32'h0, 1'b0, 0, 32'h1234_5678, 1'b1);
        go_idle();
        chk("err_cleared", up_pslverr, 1);
        do_xfer(32'h1A10_000C, 32'h0, 1'b0, 1, 32'hCAFE_F00D, 1'b0);
        go_idle();

        // Upstream drops psel right after setup
        @(posedge HCLK); #1;
        up_psel = 1'b1; up_penable = 1'b0; up_paddr = 32'h1A10_0010; up_pwrite = 1'b0;
        @(posedge HCLK); #1;
        up_psel = 1'b0;
        @(negedge HCLK);
        chk("viol_setup_dn_psel", dn_psel, 1);
        @(posedge HCLK); #1;
        dn_pready = 1'b1; dn_prdata = 32'h0BAD_F00D;
        @(negedge HCLK);
        chk("viol_acc_dn_penable", dn_penable, 1);
        @(posedge HCLK); #1;
        dn_pready = 1'b0;
        @(negedge HCLK);
        chk("viol_resp_up_pready", up_pready, 1);
        chk("viol_resp_up_prdata", up_prdata, 32'h0BAD_F00D);
        @(posedge HCLK); #1;
        @(negedge HCLK);
        chk("viol_idle_up_pready", up_pready, 0);
        chk("viol_idle_dn_psel", dn_psel, 0);
        @(posedge HCLK); #1;
        @(negedge HCLK);
        chk("viol_no_restart", dn_psel, 0);

        // Reset asserted while the slave is stalling in access
        @(posedge HCLK); #1;
        up_psel = 1'b1; up_penable = 1'b0; up_paddr = 32'h1A10_0020;
        up_pwdata = 32'h0000_0055; up_pwrite = 1'b1;
        @(posedge HCLK); #1;
        up_penable = 1'b1;
        @(posedge HCLK); #1;
        dn_pready = 1'b0;
        @(negedge HCLK);
        chk("rst_pre_dn_penable", dn_penable, 1);
        #1 HRESETn = 1'b0;
        #1;
        chk_all_zero("midrst");
        @(posedge HCLK); #1;
        up_psel = 1'b0; up_penable = 1'b0;
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        @(negedge HCLK);
        chk("postrst_up_pready", up_pready, 0);
        chk("postrst_dn_psel", dn_psel, 0);
        do_xfer(32'h1A10_0030, 32'h0, 1'b0, 1, 32'h600D_CAFE, 1'b0);
        go_idle();

        // Four back-to-back zero-wait transfers
        do_xfer(32'h1A10_0100, 32'h0,         1'b0, 0, 32'h1111_1111, 1'b0);
        do_xfer(32'h1A10_0104, 32'hA0A0_0001, 1'b1, 0, 32'h0,         1'b0);
        do_xfer(32'h1A10_0108, 32'hB0B0_0002, 1'b1, 0, 32'h0,         1'b0);
        do_xfer(32'h1A10_010C, 32'h0,         1'b0, 0, 32'h4444_4444, 1'b0);

`ifdef APB_SLICE_TIMEOUT_EN
        // Slave never ready: aborted after eight access cycles
        @(posedge HCLK); #1;
        up_psel = 1'b1; up_penable = 1'b0; up_paddr = 32'h1A10_0040; up_pwrite = 1'b0;
        dn_pready = 1'b0;
        @(posedge HCLK); #1;
        up_penable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge HCLK); #1;
            @(negedge HCLK);
            chk("to_acc_dn_penable", dn_penable, 1);
            chk("to_acc_up_pready", up_pready, 0);
        end
        @(posedge HCLK); #1;
        @(negedge HCLK);
        chk("to_dn_psel", dn_psel, 0);
        chk("to_up_pready", up_pready, 1);
        chk("to_up_pslverr", up_pslverr, 1);
        chk("to_up_prdata", up_prdata, 0);
        go_idle();
`else
        // Without the watchdog a long stall simply completes
        do_xfer(32'h1A10_0040, 32'h0, 1'b0, 20, 32'h7777_1234, 1'b0);
        go_idle();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_reg_slice.md
# apb_reg_slice

Parametrised registered APB3 bridge that replaces straight wire-through connection of an APB master port to an APB slave port. It registers the full request and response paths, so long APB routes between the peripheral bridge and remote peripherals can be cut for timing closure. It optionally aborts downstream transfers that never complete. It sits between the AHB-to-APB bridge/APB interconnect output and a single peripheral.

## Interface
Parameters:
- ADDR_WIDTH, 32, width of paddr on both sides
- DATA_WIDTH, 32, width of pwdata/prdata on both sides
- TIMEOUT_CYCLES, 256, downstream access-phase cycles before abort; only used with APB_SLICE_TIMEOUT_EN; legal range 1..65535

Ports:
- HCLK  in  1  clock
- HRESETn  in  1  asynchronous active-low reset
- up_paddr  in  ADDR_WIDTH  upstream address
- up_pwdata  in  DATA_WIDTH  upstream write data
- up_pwrite  in  1  upstream write flag
- up_psel  in  1  upstream select
- up_penable  in  1  upstream enable
- up_prdata  out  DATA_WIDTH  registered read data to master
- up_pready  out  1  registered ready to master
- up_pslverr  out  1  registered error to master
- dn_paddr  out  ADDR_WIDTH  registered address to slave
- dn_pwdata  out  DATA_WIDTH  registered write data to slave
- dn_pwrite  out  1  registered write flag to slave
- dn_psel  out  1  registered select to slave
- dn_penable  out  1  registered enable to slave
- dn_prdata  in  DATA_WIDTH  slave read data
- dn_pready  in  1  slave ready
- dn_pslverr  in  1  slave error

## Operation
- FSM states: IDLE, DSETUP, DACCESS, RESP.
- IDLE: up_pready=0, dn_psel=0. On up_psel=1, capture paddr/pwdata/pwrite into request registers, go DSETUP.
- DSETUP: dn_psel=1, dn_penable=0, request registers driven; go DACCESS next cycle.
- DACCESS: dn_psel=1, dn_penable=1. On dn_pready=1: capture dn_prdata (reads only; writes capture 0) and dn_pslverr, go RESP.
- RESP: up_pready=1 for exactly one cycle with registered prdata/pslverr; dn_psel=0; go IDLE.
- dn_p* request outputs hold last captured value while idle; only dn_psel/dn_penable return to 0.
- Upstream psel dropped before RESP (protocol violation): downstream transfer still completes, response pulse still issued, FSM returns to IDLE; no hang.
- Reset asserted mid-transfer: FSM to IDLE immediately, downstream transfer abandoned, no response issued.

## Timing
- Reset values: up_prdata=0, up_pready=0, up_pslverr=0, dn_paddr=0, dn_pwdata=0, dn_pwrite=0, dn_psel=0, dn_penable=0, timeout counter=0.
- Upstream setup in cycle T0 (captured); dn setup T1; dn access T2; dn_pready at T2 -> up_pready=1 at T3. Minimum upstream transfer 4 cycles (2 added wait states); each downstream wait state adds one.
- No combinational path from any input to any output.
- Back-to-back: next upstream setup is the IDLE cycle after RESP and is captured there; max throughput one transfer per 4 cycles.

## Configuration
- APB_SLICE_TIMEOUT_EN defined: counter increments each DACCESS cycle with dn_pready=0; when it reaches TIMEOUT_CYCLES, dn_psel/dn_penable drop, FSM goes RESP with up_pslverr=1, up_prdata=0; counter clears on leaving DACCESS. dn_pready in the same cycle as expiry wins (normal completion).
- Not defined: no counter, DACCESS waits indefinitely; TIMEOUT_CYCLES ignored.

## Structure
- Package apb_slice_pkg: state enum (IDLE, DSETUP, DACCESS, RESP), localparam TIMEOUT_CNT_WIDTH=16.
- Sub-module apb_slice_timer (counter with clear, enable, expiry flag), instantiated only under APB_SLICE_TIMEOUT_EN.

## Test plan
- Read from 0x1A10_0004, slave pready immediately, prdata=0xDEADBEEF -> up_pready high 3 cycles after setup cycle, up_prdata=0xDEADBEEF, pslverr=0.
- Write 0x0000_00A5 to 0x1A10_2000, slave inserts 3 wait states -> dn_pwdata=0xA5, dn_penable held 4 cycles, up_pready one cycle later, up_prdata=0.
- Slave returns pslverr=1 on read -> up_pslverr=1 with up_pready, returns to IDLE, next transfer clean.
- Timeout enabled, TIMEOUT_CYCLES=8, slave never ready -> dn_psel drops after 8 access cycles, up_pready=1, up_pslverr=1, up_prdata=0.
- HRESETn asserted during DACCESS -> all outputs 0 asynchronously; after release, new read completes normally.
- Four back-to-back transfers with zero-wait slave -> each completes in 4 cycles, captured addresses/data match in order.
